// File: rtl/memory_resp_demux_if.sv
// ============================================================================
//  Module      : memory_resp_demux_if
//  Description : Bundle between the memory unit, the six requester FSMs and
//                the response demux. The master side drives the select,
//                execute strobe and memory completion; the slave side (the
//                demux) returns the routed completion pulses and status.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface memory_resp_demux_if #(
    parameter int DATA_WIDTH = 64
);
    logic [2:0]            sel;
    logic                  execute;
    logic                  mem_finished;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  finished_a;
    logic                  finished_b;
    logic                  finished_c;
    logic                  finished_d;
    logic                  finished_e;
    logic                  finished_f;
    logic                  busy;
    logic [2:0]            owner;
    logic                  stray_err;
    logic                  sel_err;
    logic                  timeout;

    modport master (
        output sel, execute, mem_finished, mem_read_data,
        input  read_data, finished_a, finished_b, finished_c, finished_d,
               finished_e, finished_f, busy, owner, stray_err, sel_err, timeout
    );

    modport slave (
        input  sel, execute, mem_finished, mem_read_data,
        output read_data, finished_a, finished_b, finished_c, finished_d,
               finished_e, finished_f, busy, owner, stray_err, sel_err, timeout
    );
endinterface

`default_nettype wire

// File: rtl/memory_resp_demux.sv
// ============================================================================
//  Module      : memory_resp_demux
//  Description : Return-path demux for the memory unit. Latches the requester
//                select at the execute that starts a transaction and routes
//                the completion pulse and read data back to that requester
//                only, regardless of later select changes.
//  Options     : define RESP_TIMEOUT_EN to abort a WAIT lasting TIMEOUT_CYCLES
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_resp_demux #(
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic           clk,
    input  wire logic           rst,
    memory_resp_demux_if.slave  bus
);

    // Requester select codes; a=TRAVERSAL .. f=EDIT follow this order.
    localparam logic [2:0] MUX_TRAVERSAL = 3'd0;
    localparam logic [2:0] MUX_EXECUTE   = 3'd1;
    localparam logic [2:0] MUX_CELL      = 3'd2;
    localparam logic [2:0] MUX_INCR      = 3'd3;
    localparam logic [2:0] MUX_EQUAL     = 3'd4;
    localparam logic [2:0] MUX_EDIT      = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Catch an out-of-range timeout at elaboration rather than in silicon.
    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range_err
            $error("memory_resp_demux: TIMEOUT_CYCLES must be in 1..65535");
        end
    endgenerate

    state_t                state;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic [5:0]            finished_q;
    logic                  busy_q;
    logic [2:0]            owner_q;
    logic                  stray_err_q;
    logic                  sel_err_q;
    logic                  sel_defined;

`ifdef RESP_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_count;
    logic        timeout_q;
`endif

    // Codes 6 and 7 have no requester behind them.
    assign sel_defined = (bus.sel <= MUX_EDIT);

    // Transaction FSM: ownership capture, completion routing and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            read_data_q <= '0;
            finished_q  <= '0;
            busy_q      <= 1'b0;
            owner_q     <= 3'b000;
            stray_err_q <= 1'b0;
            sel_err_q   <= 1'b0;
`ifdef RESP_TIMEOUT_EN
            wait_count  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            // Pulses last a single cycle unless re-armed below.
            finished_q <= '0;
`ifdef RESP_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    // A completion with nothing outstanding is flagged, but a
                    // simultaneous execute is still accepted.
                    if (bus.mem_finished) begin
                        stray_err_q <= 1'b1;
                    end
                    if (bus.execute) begin
                        if (sel_defined) begin
                            owner_q <= bus.sel;
                            busy_q  <= 1'b1;
                            state   <= S_WAIT;
`ifdef RESP_TIMEOUT_EN
                            wait_count <= '0;
`endif
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end
                end

                S_WAIT: begin
                    // sel/execute are ignored here so ownership cannot move.
                    if (bus.mem_finished) begin
                        read_data_q <= bus.mem_read_data;
                        finished_q  <= 6'd1 << owner_q;
                        state       <= S_DONE;
`ifdef RESP_TIMEOUT_EN
                    end else if (wait_count == TIMEOUT_LIMIT) begin
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= S_IDLE;
                    end else if (wait_count != 16'hFFFF) begin
                        wait_count <= wait_count + 16'd1;
`endif
                    end
                end

                S_DONE: begin
                    // Completion pulse is visible this cycle; execute here is
                    // dropped and must be re-issued from IDLE.
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                    if (bus.mem_finished) begin
                        stray_err_q <= 1'b1;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.read_data  = read_data_q;
    assign bus.finished_a = finished_q[MUX_TRAVERSAL];
    assign bus.finished_b = finished_q[MUX_EXECUTE];
    assign bus.finished_c = finished_q[MUX_CELL];
    assign bus.finished_d = finished_q[MUX_INCR];
    assign bus.finished_e = finished_q[MUX_EQUAL];
    assign bus.finished_f = finished_q[MUX_EDIT];
    assign bus.busy       = busy_q;
    assign bus.owner      = owner_q;
    assign bus.stray_err  = stray_err_q;
    assign bus.sel_err    = sel_err_q;
`ifdef RESP_TIMEOUT_EN
    assign bus.timeout    = timeout_q;
`else
    assign bus.timeout    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_memory_resp_demux.sv
// ============================================================================
//  Module      : tb_memory_resp_demux
//  Description : Self-checking bench for memory_resp_demux. Expected
//                completions are queued when a transaction is issued and
//                matched against every finished_x pulse the demux produces.
//  Options     : RESP_TIMEOUT_EN selects the abort scenarios
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_resp_demux;

    localparam logic [2:0] M_TRAV  = 3'd0;
    localparam logic [2:0] M_EXEC  = 3'd1;
    localparam logic [2:0] M_CELL  = 3'd2;
    localparam logic [2:0] M_INCR  = 3'd3;
    localparam logic [2:0] M_EQUAL = 3'd4;
    localparam logic [2:0] M_EDIT  = 3'd5;

    typedef struct {
        logic [2:0]  owner;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   comp_cnt = 0;
    int   err_cnt  = 0;
    logic mon_en   = 1'b0;
    exp_t sb[$];

    memory_resp_demux_if #(.DATA_WIDTH(64)) bus ();

    memory_resp_demux #(
        .DATA_WIDTH     (64),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] fin_vec();
        return {bus.finished_f, bus.finished_e, bus.finished_d,
                bus.finished_c, bus.finished_b, bus.finished_a};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every completion pulse must match the oldest
    // outstanding expectation in owner and data.
    logic [5:0] mon_fv;
    logic [5:0] mon_exp;
    exp_t       mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_fv = fin_vec();
            if (mon_fv !== 6'b0) begin
                comp_cnt++;
                if (sb.size() == 0) begin
                    err_cnt++;
                    $display("FAIL unexpected_finished: got finished=%b want none", mon_fv);
                end else begin
                    mon_e   = sb.pop_front();
                    mon_exp = 6'b000001 << mon_e.owner;
                    if (mon_fv !== mon_exp || bus.read_data !== mon_e.data) begin
                        err_cnt++;
                        $display("FAIL completion: got finished=%b data=%h want finished=%b data=%h",
                                 mon_fv, bus.read_data, mon_exp, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.sel = 3'd0; bus.execute = 1'b0; bus.mem_finished = 1'b0; bus.mem_read_data = '0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        comp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        comp_cnt++; if (bus.read_data !== 64'd0) begin err_cnt++; $display("FAIL reset_read_data: got %h want 0", bus.read_data); end
        comp_cnt++; if (fin_vec() !== 6'b0) begin err_cnt++; $display("FAIL reset_finished: got %b want 0", fin_vec()); end
        comp_cnt++; if (bus.owner !== 3'b000) begin err_cnt++; $display("FAIL reset_owner: got %0d want 0", bus.owner); end
        comp_cnt++; if (bus.stray_err !== 1'b0) begin err_cnt++; $display("FAIL reset_stray_err: got %b want 0", bus.stray_err); end
        comp_cnt++; if (bus.sel_err !== 1'b0) begin err_cnt++; $display("FAIL reset_sel_err: got %b want 0", bus.sel_err); end
        comp_cnt++; if (bus.timeout !== 1'b0) begin err_cnt++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
        mon_en = 1'b1;
    endtask

    task automatic test_cell();
        int busy_cnt = 0;
        int fc_cnt   = 0;
        int other    = 0;
        int fc_at    = -1;
        bus.sel = M_CELL; bus.execute = 1'b1;
        sb.push_back('{M_CELL, 64'hDEAD_BEEF});
        for (int t = 1; t <= 7; t++) begin
            cyc();
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.finished_c === 1'b1) begin fc_cnt++; fc_at = t; end
            other += $countones(fin_vec() & 6'b111011);
            bus.execute       = 1'b0;
            bus.mem_finished  = (t == 3);
            bus.mem_read_data = (t == 3) ? 64'hDEAD_BEEF : 64'h1111_2222_3333_4444;
        end
        comp_cnt++; if (busy_cnt != 4) begin err_cnt++; $display("FAIL cell_busy_cycles: got %0d want 4", busy_cnt); end
        comp_cnt++; if (fc_cnt != 1) begin err_cnt++; $display("FAIL cell_finished_count: got %0d want 1", fc_cnt); end
        comp_cnt++; if (fc_at != 4) begin err_cnt++; $display("FAIL cell_finished_cycle: got %0d want 4", fc_at); end
        comp_cnt++; if (other != 0) begin err_cnt++; $display("FAIL cell_other_finished: got %0d want 0", other); end
        comp_cnt++; if (bus.read_data !== 64'hDEAD_BEEF) begin err_cnt++; $display("FAIL cell_read_data: got %h want deadbeef", bus.read_data); end
    endtask

    task automatic test_owner_hold();
        int fd_cnt = 0;
        int ff_cnt = 0;
        int owner_bad = 0;
        bus.sel = M_INCR; bus.execute = 1'b1;
        sb.push_back('{M_INCR, 64'd5});
        for (int t = 1; t <= 8; t++) begin
            cyc();
            if (bus.finished_d === 1'b1) fd_cnt++;
            if (bus.finished_f === 1'b1) ff_cnt++;
            if (bus.owner !== M_INCR) owner_bad++;
            bus.sel           = M_EDIT;
            bus.execute       = (t == 1 || t == 3 || t == 4);
            bus.mem_finished  = (t == 4);
            bus.mem_read_data = (t == 4) ? 64'd5 : 64'hFFFF;
        end
        comp_cnt++; if (fd_cnt != 1) begin err_cnt++; $display("FAIL hold_finished_d: got %0d want 1", fd_cnt); end
        comp_cnt++; if (ff_cnt != 0) begin err_cnt++; $display("FAIL hold_finished_f: got %0d want 0", ff_cnt); end
        comp_cnt++; if (owner_bad != 0) begin err_cnt++; $display("FAIL hold_owner: got %0d bad cycles want 0", owner_bad); end
        comp_cnt++; if (bus.read_data !== 64'd5) begin err_cnt++; $display("FAIL hold_read_data: got %h want 5", bus.read_data); end
        comp_cnt++; if (bus.sel_err !== 1'b0) begin err_cnt++; $display("FAIL hold_sel_err: got %b want 0", bus.sel_err); end
        bus.sel = 3'd0;
    endtask

    task automatic test_stray_sel();
        bus.mem_finished = 1'b1; bus.mem_read_data = 64'd7;
        cyc();
        bus.mem_finished = 1'b0;
        comp_cnt++; if (bus.stray_err !== 1'b1) begin err_cnt++; $display("FAIL stray_set: got %b want 1", bus.stray_err); end
        comp_cnt++; if (bus.read_data !== 64'd5) begin err_cnt++; $display("FAIL stray_read_data: got %h want 5", bus.read_data); end
        cyc(); cyc(); cyc();
        comp_cnt++; if (bus.stray_err !== 1'b1) begin err_cnt++; $display("FAIL stray_sticky: got %b want 1", bus.stray_err); end
        bus.sel = 3'b111; bus.execute = 1'b1;
        cyc();
        bus.execute = 1'b0;
        comp_cnt++; if (bus.sel_err !== 1'b1) begin err_cnt++; $display("FAIL sel_err_set: got %b want 1", bus.sel_err); end
        comp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL sel_err_busy: got %b want 0", bus.busy); end
        comp_cnt++; if (bus.owner !== M_INCR) begin err_cnt++; $display("FAIL sel_err_owner: got %0d want %0d", bus.owner, M_INCR); end
        cyc(); cyc();
        comp_cnt++; if (bus.sel_err !== 1'b1 || bus.busy !== 1'b0) begin err_cnt++; $display("FAIL sel_err_sticky: got sel_err=%b busy=%b want 1/0", bus.sel_err, bus.busy); end
        bus.sel = 3'd0;
    endtask

    task automatic test_reset_mid_wait();
        int pulses = 0;
        bus.sel = M_TRAV; bus.execute = 1'b1;
        cyc();
        bus.execute = 1'b0;
        comp_cnt++; if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        comp_cnt++; if (bus.busy !== 1'b0 || bus.stray_err !== 1'b0 || bus.sel_err !== 1'b0) begin
            err_cnt++; $display("FAIL midrst_state: got busy=%b stray=%b sel_err=%b want 0/0/0", bus.busy, bus.stray_err, bus.sel_err);
        end
        comp_cnt++; if (bus.owner !== 3'd0 || bus.read_data !== 64'd0) begin
            err_cnt++; $display("FAIL midrst_regs: got owner=%0d data=%h want 0/0", bus.owner, bus.read_data);
        end
        bus.mem_finished = 1'b1; bus.mem_read_data = 64'd9;
        for (int t = 0; t < 4; t++) begin
            cyc();
            bus.mem_finished = 1'b0;
            pulses += $countones(fin_vec());
        end
        comp_cnt++; if (pulses != 0) begin err_cnt++; $display("FAIL midrst_pulses: got %0d want 0", pulses); end
        comp_cnt++; if (bus.stray_err !== 1'b1) begin err_cnt++; $display("FAIL midrst_stray: got %b want 1", bus.stray_err); end
        comp_cnt++; if (bus.busy !== 1'b0 || bus.read_data !== 64'd0) begin
            err_cnt++; $display("FAIL midrst_after: got busy=%b data=%h want 0/0", bus.busy, bus.read_data);
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        // finished and execute together in IDLE
        bus.sel = M_EQUAL; bus.execute = 1'b1; bus.mem_finished = 1'b1; bus.mem_read_data = 64'd3;
        sb.push_back('{M_EQUAL, 64'hA5});
        cyc();
        bus.execute = 1'b0; bus.mem_finished = 1'b0;
        comp_cnt++; if (bus.busy !== 1'b1 || bus.owner !== M_EQUAL) begin
            err_cnt++; $display("FAIL b2b_accept: got busy=%b owner=%0d want 1/%0d", bus.busy, bus.owner, M_EQUAL);
        end
        comp_cnt++; if (bus.stray_err !== 1'b1) begin err_cnt++; $display("FAIL b2b_stray: got %b want 1", bus.stray_err); end
        cyc();
        bus.mem_finished = 1'b1; bus.mem_read_data = 64'hA5;
        cyc();
        bus.mem_finished = 1'b0;
        comp_cnt++; if (bus.finished_e !== 1'b1) begin err_cnt++; $display("FAIL b2b_finished_e: got %b want 1", bus.finished_e); end
        // execute during DONE must be dropped
        bus.sel = M_EXEC; bus.execute = 1'b1;
        cyc();
        comp_cnt++; if (bus.busy !== 1'b0 || bus.owner !== M_EQUAL) begin
            err_cnt++; $display("FAIL b2b_done_exec: got busy=%b owner=%0d want 0/%0d", bus.busy, bus.owner, M_EQUAL);
        end
        sb.push_back('{M_EXEC, 64'h0123});
        cyc();
        bus.execute = 1'b0;
        comp_cnt++; if (bus.busy !== 1'b1 || bus.owner !== M_EXEC) begin
            err_cnt++; $display("FAIL b2b_reissue: got busy=%b owner=%0d want 1/%0d", bus.busy, bus.owner, M_EXEC);
        end
        bus.mem_finished = 1'b1; bus.mem_read_data = 64'h0123;
        cyc();
        bus.mem_finished = 1'b0;
        comp_cnt++; if (bus.finished_b !== 1'b1 || bus.read_data !== 64'h0123) begin
            err_cnt++; $display("FAIL b2b_finished_b: got fin=%b data=%h want 1/0123", bus.finished_b, bus.read_data);
        end
        cyc();
        comp_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_idle: got busy=%b want 0", bus.busy); end
        bus.sel = 3'd0;
    endtask

`ifdef RESP_TIMEOUT_EN
    task automatic test_timeout();
        int to_cnt = 0;
        int to_at  = -1;
        int fe_cnt = 0;
        logic busy_at5 = 1'b1;
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        bus.sel = M_EQUAL; bus.execute = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            cyc();
            bus.execute = 1'b0;
            if (bus.timeout === 1'b1) begin to_cnt++; to_at = t; end
            if (t == 5) busy_at5 = bus.busy;
            fe_cnt += $countones(fin_vec());
        end
        comp_cnt++; if (to_cnt != 1 || to_at != 5) begin err_cnt++; $display("FAIL timeout_pulse: got count=%0d at=%0d want 1 at 5", to_cnt, to_at); end
        comp_cnt++; if (busy_at5 !== 1'b0) begin err_cnt++; $display("FAIL timeout_busy: got %b want 0", busy_at5); end
        comp_cnt++; if (fe_cnt != 0 || bus.read_data !== 64'd0) begin
            err_cnt++; $display("FAIL timeout_no_finish: got pulses=%0d data=%h want 0/0", fe_cnt, bus.read_data);
        end
        // completion on the limit cycle wins
        to_cnt = 0; fe_cnt = 0;
        bus.sel = M_EQUAL; bus.execute = 1'b1;
        sb.push_back('{M_EQUAL, 64'h77});
        for (int t = 1; t <= 8; t++) begin
            cyc();
            bus.execute       = 1'b0;
            bus.mem_finished  = (t == 4);
            bus.mem_read_data = 64'h77;
            if (bus.timeout === 1'b1) to_cnt++;
            if (bus.finished_e === 1'b1) fe_cnt++;
        end
        comp_cnt++; if (to_cnt != 0 || fe_cnt != 1) begin
            err_cnt++; $display("FAIL timeout_race: got timeouts=%0d finished_e=%0d want 0/1", to_cnt, fe_cnt);
        end
    endtask
`else
    task automatic test_no_timeout();
        int to_cnt = 0;
        int busy_cnt = 0;
        bus.sel = M_CELL; bus.execute = 1'b1;
        sb.push_back('{M_CELL, 64'h55AA});
        for (int t = 1; t <= 24; t++) begin
            cyc();
            bus.execute       = 1'b0;
            bus.mem_finished  = (t == 20);
            bus.mem_read_data = 64'h55AA;
            if (bus.timeout === 1'b1) to_cnt++;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        comp_cnt++; if (to_cnt != 0) begin err_cnt++; $display("FAIL no_timeout_pulse: got %0d want 0", to_cnt); end
        comp_cnt++; if (busy_cnt != 21) begin err_cnt++; $display("FAIL no_timeout_busy: got %0d want 21", busy_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_cell();
        test_owner_hold();
        test_stray_sel();
        test_reset_mid_wait();
        test_back_to_back();
`ifdef RESP_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        cyc(); cyc();
        comp_cnt++;
        if (sb.size() != 0) begin
            err_cnt++;
            $display("FAIL scoreboard_drain: got %0d outstanding want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/memory_resp_demux.md
Name: memory_resp_demux

Overview:
- Return-path counterpart to the memory request mux: routes memory-unit completions and read data back to the requester that issued the transaction.
- Captures the owner, the current `sel` code, at the `execute` that starts a transaction. Holds ownership until the memory unit reports `finished`.
- Sits between the memory unit outputs and the six requester FSMs: traversal, execute, cell, incr, equal, edit.
- Purpose: a requester never sees another requester's completion, even if `sel` changes mid-transaction.

Parameters:
- DATA_WIDTH, `memory_data_width`, width of memory read data; must equal `memory_data_width`.
- TIMEOUT_CYCLES, 255, cycles WAIT may last before abort; only used with RESP_TIMEOUT_EN; range 1..65535.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sel  input  3  current mux select, `MUX_*` codes from memory_mux.vh
- execute  input  1  muxed execute strobe as presented to the memory unit
- mem_finished  input  1  memory unit completion pulse
- mem_read_data  input  DATA_WIDTH  memory unit read data, valid with mem_finished
- read_data  output  DATA_WIDTH  registered read data of the last completed transaction
- finished_a..finished_f  output  1 each  one-cycle completion pulse per requester (a=TRAVERSAL, b=EXECUTE, c=CELL, d=INCR, e=EQUAL, f=EDIT)
- busy  output  1  transaction outstanding
- owner  output  3  latched sel of the outstanding or last transaction
- stray_err  output  1  sticky: mem_finished seen with no transaction outstanding
- sel_err  output  1  sticky: execute seen with an undefined sel code
- timeout  output  1  one-cycle abort pulse (RESP_TIMEOUT_EN only)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst, sampled at posedge clk, and has priority over all else.
- Reset values:
  - state=IDLE
  - read_data=0
  - finished_a..f=0
  - busy=0
  - owner=3'b000
  - stray_err=0, sel_err=0
  - timeout=0
  - timeout counter=0
- States: IDLE, WAIT, DONE.
- IDLE:
  - execute=1 with sel a defined `MUX_*` code: owner<=sel, busy<=1, counter<=0, go WAIT.
  - execute=1 with undefined sel: sel_err<=1, stay IDLE, owner unchanged.
  - mem_finished=1: stray_err<=1, read_data unchanged. This also applies when mem_finished and execute are both high in the same cycle; the execute is still accepted.
- WAIT:
  - sel and execute are ignored. A requester change or re-issue does not alter owner.
  - mem_finished=1: read_data<=mem_read_data, go DONE.
  - Otherwise counter increments.
- DONE, exactly one cycle:
  - finished_<owner>=1; all other finished_x=0.
  - busy<=0 at the end of the cycle; go IDLE.
  - execute in DONE is not accepted. The requester must re-issue in IDLE.
  - mem_finished in DONE sets stray_err.
- Latency: mem_finished sampled at edge N drives finished_x high in the cycle after edge N. read_data is valid that same cycle and holds until the next completion.
- Invariant: at most one finished_x is high in any cycle.
- Sticky flags stray_err and sel_err clear only on rst.
- Reset mid-WAIT: transaction dropped, no finished pulse, all outputs to their reset values.
- Counter is 16 bits and saturates; it never wraps.

Optional Feature:
- Macro: RESP_TIMEOUT_EN.
- Defined:
  - In WAIT, if counter reaches TIMEOUT_CYCLES-1 without mem_finished, pulse timeout=1 for one cycle, go IDLE, busy<=0, no finished_x.
  - read_data is unchanged on abort.
  - mem_finished on the exact cycle the counter hits the limit wins: normal completion, no timeout.
- Undefined:
  - No counter logic. WAIT lasts indefinitely.
  - timeout output tied to 0.

Test Plan:
- rst high 2 cycles, then low -> all outputs 0, busy=0, state IDLE.
- sel=`MUX_CELL`, execute=1 one cycle; mem_finished with data 64'hDEAD_BEEF after 3 cycles -> busy=1 for 4 cycles. finished_c=1 exactly one cycle, the cycle after mem_finished. read_data=DEAD_BEEF. All other finished_x=0.
- sel=`MUX_INCR`, execute; sel switches to `MUX_EDIT` with execute pulses during WAIT; complete with data 5 -> finished_d pulses, finished_f never pulses, owner=`MUX_INCR`.
- mem_finished=1 in IDLE with data 7 -> stray_err=1 and stays set, read_data unchanged, no finished_x. execute with sel=3'b111 -> sel_err=1, busy stays 0.
- rst asserted 2 cycles into WAIT, then mem_finished -> no finished_x pulse, busy=0, stray_err=1 from the post-reset finished.
- RESP_TIMEOUT_EN with TIMEOUT_CYCLES=4, execute, no mem_finished -> timeout pulses on the 4th WAIT cycle, busy=0, no finished_x. Repeat with mem_finished on the 4th cycle -> normal finished, timeout=0.
